frame_buffer_arbiter: RTL

//  Shares the single-port pixel frame-buffer RAM between the HDMI display read

---
 rtl/frame_buffer_arbiter_if.sv | 59 +++++
 rtl/frame_buffer_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_arbiter_if.sv
// ----------------------------------------------------------------------------
// frame_buffer_arbiter_if
// Bundles every non-clock signal of the frame-buffer arbiter: the display read
// port, the host write port, the RAM port and the status/control signals.
//
// Modports
//   slave  : the arbiter itself (consumes requests, drives RAM and status)
//   master : the surrounding system (display controller, host loader, RAM)
//
// Signal summary
//   RD_REQ / RD_ADDR          display read request and address
//   RD_DATA / RD_VALID        read data returned two cycles after RD_REQ
//   WR_VALID / WR_READY       host write handshake
//   WR_ADDR / WR_DATA         host write payload
//   MEM_ADDR/MEM_WE/MEM_WDATA registered RAM command
//   MEM_RDATA                 RAM read data for the current MEM_ADDR
//   FIFO_LEVEL                number of buffered host writes
//   STARVED / STARVE_CLR      sticky write-starvation flag and its clear
// ----------------------------------------------------------------------------
interface frame_buffer_arbiter_if #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              RD_REQ;
    logic [ADDR_W-1:0] RD_ADDR;
    logic [DATA_W-1:0] RD_DATA;
    logic              RD_VALID;

    // Host write handshake: a write transfers on a rising CLK_PX edge where
    // WR_VALID && WR_READY are both high. WR_READY never depends on WR_VALID.
    logic              WR_VALID;
    logic              WR_READY;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;

    logic [ADDR_W-1:0] MEM_ADDR;
    logic              MEM_WE;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [DATA_W-1:0] MEM_RDATA;

    logic [LVL_W-1:0]  FIFO_LEVEL;
    logic              STARVED;
    logic              STARVE_CLR;

    modport slave (
        input  RD_REQ, RD_ADDR, WR_VALID, WR_ADDR, WR_DATA, MEM_RDATA, STARVE_CLR,
        output RD_DATA, RD_VALID, WR_READY, MEM_ADDR, MEM_WE, MEM_WDATA,
               FIFO_LEVEL, STARVED
    );

    modport master (
        output RD_REQ, RD_ADDR, WR_VALID, WR_ADDR, WR_DATA, MEM_RDATA, STARVE_CLR,
        input  RD_DATA, RD_VALID, WR_READY, MEM_ADDR, MEM_WE, MEM_WDATA,
               FIFO_LEVEL, STARVED
    );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// ----------------------------------------------------------------------------
// frame_buffer_arbiter
// Shares a single-port pixel frame-buffer RAM between the real-time display
// read port (strict priority) and a host write port. Host writes are queued in
// a FIFO and drained into RAM on any cycle without a display read, which in
// practice means during blanking.
//
// Ports
//   CLK_PX   in   pixel clock, all logic on the rising edge
//   RST_n    in   asynchronous active-low reset; drops queued writes and any
//                 read in flight
//   bus      slave modport of frame_buffer_arbiter_if (read, write, RAM and
//                 status signals)
//   o_state  out  registered grant state (0 IDLE, 1 READ, 2 WRITE) for debug
//
// Read timing: RD_REQ sampled at edge N puts RD_ADDR on MEM_ADDR for cycle
// N+1; MEM_ADDR acts as the RAM's address register, so MEM_RDATA is valid
// during that same cycle and is captured into RD_DATA, visible at N+2.
// ----------------------------------------------------------------------------
module frame_buffer_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic                    CLK_PX,
    input  logic                    RST_n,
    frame_buffer_arbiter_if.slave   bus,
    output logic [1:0]              o_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;

    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_starved;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_FULL);
    // Ready comes only from the registered level, so a full FIFO refuses a
    // push even on a cycle where it also pops.
    assign w_push  = bus.WR_VALID && !w_full;
    // A pop happens exactly when the FSM takes a WRITE grant this cycle.
    assign w_pop   = !bus.RD_REQ && !w_empty;

    assign bus.WR_READY   = !w_full;
    assign bus.FIFO_LEVEL = r_level;
    assign bus.MEM_ADDR   = r_mem_addr;
    assign bus.MEM_WE     = r_mem_we;
    assign bus.MEM_WDATA  = r_mem_wdata;
    assign bus.RD_DATA    = r_rd_data;
    assign bus.RD_VALID   = r_rd_valid;
    assign bus.STARVED    = r_starved;
    assign o_state        = r_state;

    // ------------------------------------------------------------------
    // Write FIFO storage (no reset needed: only entries between the
    // pointers are ever read)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_PX) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.WR_ADDR;
            r_fifo_data[r_wr_ptr] <= bus.WR_DATA;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge CLK_PX or negedge RST_n) begin
        if (!RST_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Grant FSM with registered RAM command. The next state depends only on
    // this cycle's inputs; the display read always wins.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_PX or negedge RST_n) begin
        if (!RST_n) begin
            r_state     <= ST_IDLE;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
        end else if (bus.RD_REQ) begin
            r_state    <= ST_READ;
            r_mem_addr <= bus.RD_ADDR;
            r_mem_we   <= 1'b0;
        end else if (!w_empty) begin
            r_state     <= ST_WRITE;
            r_mem_addr  <= r_fifo_addr[r_rd_ptr];
            r_mem_wdata <= r_fifo_data[r_rd_ptr];
            r_mem_we    <= 1'b1;
        end else begin
            // MEM_ADDR and MEM_WDATA hold their last values while idle.
            r_state  <= ST_IDLE;
            r_mem_we <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read return path: capture RAM data on the cycle after a READ grant
    // was registered. RD_DATA keeps its last value otherwise.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_PX or negedge RST_n) begin
        if (!RST_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= (r_state == ST_READ);
            if (r_state == ST_READ) begin
                r_rd_data <= bus.MEM_RDATA;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write starvation monitor. The counter runs while writes are queued
    // and none is granted, and saturates at the limit. A clear also
    // restarts the count, so a persisting starvation is reported again a
    // full STARVE_LIMIT cycles after software acknowledged it.
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_next = r_starve_cnt;
        if (w_empty || w_pop || bus.STARVE_CLR) begin
            w_cnt_next = '0;
        end else if (r_starve_cnt != CNT_LIMIT) begin
            w_cnt_next = r_starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK_PX or negedge RST_n) begin
        if (!RST_n) begin
            r_starve_cnt <= '0;
            r_starved    <= 1'b0;
        end else begin
            r_starve_cnt <= w_cnt_next;
            if (bus.STARVE_CLR) begin
                r_starved <= 1'b0;
            end else if (w_cnt_next == CNT_LIMIT) begin
                r_starved <= 1'b1;
            end
        end
    end
endmodule
